tower_unit: RTL and testbench

Parametrised tower health/lifecycle controller, successor to the single-source fixed-width tower. Each instance tracks one tower (player or enemy) through idle, deploy, alive and dead phases. It accepts NUM_SRC simultaneous damage sources with saturating arithmetic, applies optional periodic regeneration on game ticks, and signals death and level completion to the level sequencer.

---
 rtl/tower_unit_if.sv | 29 ++
 rtl/tower_unit.sv | 162 ++++++++++++++++
 tb/tb_tower_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tower_unit_if.sv
// Sequencer-facing bundle for one tower: game controls in, health/lifecycle status out.
// master drives the controls (sequencer or bench), slave is the tower itself.
interface tower_unit_if #(
  parameter int HP_W    = 8,
  parameter int NUM_SRC = 2,
  parameter int POS_W   = 9
);
  logic                    gameTick;
  logic                    player;
  logic                    startLevel;
  logic [NUM_SRC-1:0]      attackSCEN;
  logic [NUM_SRC*HP_W-1:0] damageIn;
  logic [HP_W-1:0]         health;
  logic [POS_W-1:0]        position;
  logic                    alive;
  logic                    dead;
  logic                    hit;
  logic                    levelComplete;

  modport master (
    output gameTick, player, startLevel, attackSCEN, damageIn,
    input  health, position, alive, dead, hit, levelComplete
  );

  modport slave (
    input  gameTick, player, startLevel, attackSCEN, damageIn,
    output health, position, alive, dead, hit, levelComplete
  );
endinterface

// File: rtl/tower_unit.sv
// Tower health/lifecycle controller: IDLE -> DEPLOY -> ALIVE -> DEAD -> IDLE,
// multi-source saturating damage, periodic regen and timed death hold.

module tower_dmg_lane #(
  parameter int HP_W = 8
) (
  input  logic            en_i,
  input  logic [HP_W-1:0] dmg_i,
  output logic [HP_W-1:0] dmg_o
);
  assign dmg_o = en_i ? dmg_i : '0;
endmodule

module tower_unit #(
  parameter int HP_W         = 8,
  parameter int MAX_HP       = 255,
  parameter int NUM_SRC      = 2,
  parameter int DEAD_HOLD    = 10,
  parameter int REGEN_PERIOD = 16,
  parameter int REGEN_AMT    = 0,
  parameter int POS_W        = 9
) (
  input  logic        clk,
  input  logic        reset,
  tower_unit_if.slave tw
);
  localparam int DMG_W = HP_W + $clog2(NUM_SRC) + 1;
  // two guard bits so health + regen never overflows and the sign survives
  localparam int NET_W = DMG_W + 2;
  localparam int RC_W  = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
  localparam int HC_W  = $clog2(DEAD_HOLD + 1);

  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_DEPLOY = 4'b0010;
  localparam logic [3:0] S_ALIVE  = 4'b0100;
  localparam logic [3:0] S_DEAD   = 4'b1000;

  localparam logic [HP_W-1:0]         MAX_HP_V = HP_W'(MAX_HP);
  localparam logic signed [NET_W-1:0] MAX_HP_S = NET_W'(MAX_HP);
  localparam logic signed [NET_W-1:0] REGEN_S  = NET_W'(REGEN_AMT);

  logic [3:0]       state_q, state_d;
  logic [HP_W-1:0]  health_q, health_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             alive_q, alive_d;
  logic             dead_q, dead_d;
  logic             hit_q, hit_d;
  logic             lc_q, lc_d;
  logic             player_q, player_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [HC_W-1:0]  hcnt_q, hcnt_d;

  logic [NUM_SRC-1:0][HP_W-1:0] lane_dmg;
  logic [DMG_W-1:0]             dmg;
  logic                         rc_wrap, regen_fire;
  logic signed [NET_W-1:0]      net_s;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    tower_dmg_lane #(.HP_W(HP_W)) u_lane (
      .en_i  (tw.attackSCEN[g]),
      .dmg_i (tw.damageIn[g*HP_W +: HP_W]),
      .dmg_o (lane_dmg[g])
    );
  end

  always_comb begin
    dmg = '0;
    for (int i = 0; i < NUM_SRC; i++) dmg = dmg + DMG_W'(lane_dmg[i]);
  end

  assign rc_wrap    = (rcnt_q == RC_W'(REGEN_PERIOD - 1));
  assign regen_fire = tw.gameTick && (REGEN_AMT != 0) && rc_wrap;
  assign net_s      = $signed(NET_W'(health_q)) + (regen_fire ? REGEN_S : '0)
                      - $signed(NET_W'(dmg));

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    pos_d    = pos_q;
    hit_d    = 1'b0;
    lc_d     = lc_q;
    player_d = player_q;
    rcnt_d   = rcnt_q;
    hcnt_d   = hcnt_q;
    case (state_q)
      S_IDLE: begin
        if (tw.startLevel) begin
          player_d = tw.player;
          lc_d     = 1'b0;
          state_d  = S_DEPLOY;
        end
      end
      S_DEPLOY: begin
        health_d = MAX_HP_V;
        pos_d    = {POS_W{player_q}};
        rcnt_d   = '0;
        state_d  = S_ALIVE;
      end
      S_ALIVE: begin
        hit_d = (dmg != '0);
        if (tw.gameTick) rcnt_d = rc_wrap ? '0 : rcnt_q + 1'b1;
        if (net_s <= 0) begin
          health_d = '0;
          state_d  = S_DEAD;
          lc_d     = 1'b1;
          hcnt_d   = '0;
        end else if (net_s > MAX_HP_S) begin
          health_d = MAX_HP_V;
        end else begin
          health_d = net_s[HP_W-1:0];
        end
      end
      S_DEAD: begin
        health_d = '0;
        if (tw.gameTick) begin
          if (hcnt_q == HC_W'(DEAD_HOLD - 1)) begin
            hcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    alive_d = (state_d == S_ALIVE);
    dead_d  = (state_d == S_DEAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      health_q <= MAX_HP_V;
      pos_q    <= '0;
      alive_q  <= 1'b0;
      dead_q   <= 1'b0;
      hit_q    <= 1'b0;
      lc_q     <= 1'b0;
      player_q <= 1'b0;
      rcnt_q   <= '0;
      hcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      pos_q    <= pos_d;
      alive_q  <= alive_d;
      dead_q   <= dead_d;
      hit_q    <= hit_d;
      lc_q     <= lc_d;
      player_q <= player_d;
      rcnt_q   <= rcnt_d;
      hcnt_q   <= hcnt_d;
    end
  end

  assign tw.health        = health_q;
  assign tw.position      = pos_q;
  assign tw.alive         = alive_q;
  assign tw.dead          = dead_q;
  assign tw.hit           = hit_q;
  assign tw.levelComplete = lc_q;
endmodule

// File: tb/tb_tower_unit.sv
// Directed bench for tower_unit with regen enabled (5 HP every 4 ticks), 10-tick death hold.
module tb_tower_unit;
  localparam int HP_W = 8, NUM_SRC = 2, POS_W = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0, n_bad = 0;

  tower_unit_if #(.HP_W(HP_W), .NUM_SRC(NUM_SRC), .POS_W(POS_W)) tw ();

  tower_unit #(
    .HP_W(HP_W), .MAX_HP(255), .NUM_SRC(NUM_SRC), .DEAD_HOLD(10),
    .REGEN_PERIOD(4), .REGEN_AMT(5), .POS_W(POS_W)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .tw    (tw.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_src(input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1);
    tw.attackSCEN = en;
    tw.damageIn   = {d1, d0};
    cyc();
    tw.attackSCEN = '0;
  endtask

  task automatic tick();
    tw.gameTick = 1'b1;
    cyc();
    tw.gameTick = 1'b0;
  endtask

  task automatic start(input logic pl);
    tw.player     = pl;
    tw.startLevel = 1'b1;
    cyc();
    tw.startLevel = 1'b0;
    chk("deploy_alive", tw.alive, 0);
    chk("deploy_lc", tw.levelComplete, 0);
    cyc();
    chk("alive", tw.alive, 1);
    chk("alive_hp", tw.health, 255);
    chk("alive_pos", tw.position, pl ? 9'h1FF : 9'h000);
  endtask

  initial begin
    tw.gameTick = 0; tw.player = 0; tw.startLevel = 0;
    tw.attackSCEN = '0; tw.damageIn = '0;
    #12;
    chk("rst_hp", tw.health, 255);
    chk("rst_pos", tw.position, 0);
    chk("rst_alive", tw.alive, 0);
    chk("rst_dead", tw.dead, 0);
    chk("rst_hit", tw.hit, 0);
    chk("rst_lc", tw.levelComplete, 0);
    reset = 1'b1;
    cyc();

    start(1'b1);
    hit_src(2'b11, 8'd10, 8'd20);
    chk("dual_hp", tw.health, 225);
    chk("dual_hit", tw.hit, 1);
    cyc();
    chk("hit_pulse", tw.hit, 0);
    chk("hold_hp", tw.health, 225);

    hit_src(2'b11, 8'd150, 8'd45);
    chk("to30_hp", tw.health, 30);
    tw.damageIn = {8'd99, 8'd99};  // disabled sources must not hurt
    cyc();
    chk("gated_hp", tw.health, 30);
    hit_src(2'b01, 8'd30, 8'd0);
    chk("kill_hp", tw.health, 0);
    chk("kill_dead", tw.dead, 1);
    chk("kill_alive", tw.alive, 0);
    chk("kill_lc", tw.levelComplete, 1);

    tw.startLevel = 1'b1;
    cyc();
    tw.startLevel = 1'b0;
    chk("dead_ignore_start", tw.dead, 1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("dead_hold", tw.dead, (i < 10) ? 1 : 0);
      cyc();
    end
    chk("idle_alive", tw.alive, 0);
    chk("idle_lc", tw.levelComplete, 1);
    chk("idle_hp", tw.health, 0);

    start(1'b0);
    hit_src(2'b11, 8'd200, 8'd25);
    chk("to30b_hp", tw.health, 30);
    hit_src(2'b11, 8'd200, 8'd200);
    chk("nowrap_hp", tw.health, 0);
    chk("nowrap_dead", tw.dead, 1);
    chk("nowrap_hit", tw.hit, 1);
    chk("nowrap_lc", tw.levelComplete, 1);

    #2 reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_dead_hp", tw.health, 255);
    chk("rst_dead_dead", tw.dead, 0);
    cyc();

    start(1'b1);
    hit_src(2'b01, 8'd5, 8'd0);
    chk("to250_hp", tw.health, 250);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("regen_clamp", tw.health, (i < 4) ? 250 : 255);
    end

    hit_src(2'b10, 8'd0, 8'd155);
    chk("to100_hp", tw.health, 100);
    for (int i = 1; i <= 3; i++) tick();
    chk("pre_regen_hp", tw.health, 100);
    tw.gameTick = 1'b1;
    hit_src(2'b01, 8'd3, 8'd0);
    tw.gameTick = 1'b0;
    chk("regen_dmg_hp", tw.health, 102);
    chk("regen_dmg_hit", tw.hit, 1);

    hit_src(2'b01, 8'd25, 8'd0);
    chk("to77_hp", tw.health, 77);
    chk("to77_hit", tw.hit, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_hp", tw.health, 255);
    chk("arst_alive", tw.alive, 0);
    chk("arst_pos", tw.position, 0);
    chk("arst_hit", tw.hit, 0);
    chk("arst_dead", tw.dead, 0);
    chk("arst_lc", tw.levelComplete, 0);
    #3 reset = 1'b1;
    cyc();
    chk("post_rst_alive", tw.alive, 0);
    chk("post_rst_hp", tw.health, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
